// File: rtl/axi_lite_slave_regs_if.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_regs_if
//
// Purpose : AXI-Lite bundle (AW, W, B, AR, R channels) shared between the
//           register-bank responder and whatever master drives it.
//
// Parameters
//   ADDR_WIDTH : byte address width
//   DATA_WIDTH : data width (32 for the register bank)
//
// Signals (master -> slave unless noted)
//   AWADDR/AWVALID, AWREADY (slave->master)  : write address channel
//   WDATA/[WSTRB]/WVALID, WREADY (s->m)      : write data channel
//   BRESP/BVALID (s->m), BREADY              : write response channel
//   ARADDR/ARVALID, ARREADY (s->m)           : read address channel
//   RDATA/RRESP/RVALID (s->m), RREADY        : read data channel
//
// Build option
//   AXIL_WSTRB_EN : when defined, adds the WSTRB byte-lane strobe.
// ---------------------------------------------------------------------------
interface axi_lite_slave_regs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
`ifdef AXIL_WSTRB_EN
    logic [DATA_WIDTH/8-1:0] WSTRB;
`endif
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID,
        input  AWREADY,
        output WDATA,
`ifdef AXIL_WSTRB_EN
        output WSTRB,
`endif
        output WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RVALID,
        output RREADY
    );

    modport slave (
        input  AWADDR, AWVALID,
        output AWREADY,
        input  WDATA,
`ifdef AXIL_WSTRB_EN
        input  WSTRB,
`endif
        input  WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_regs
//
// Purpose : AXI-Lite responder terminating one outstanding write and one
//           outstanding read, backed by NUM_REGS 32-bit registers that are
//           also mirrored flat onto regs_o.
//
// Parameters
//   ADDR_WIDTH : byte address width
//   DATA_WIDTH : data width, must be 32 (one register = 4 bytes)
//   NUM_REGS   : register count, power of two, >= 2
//
// Ports
//   ACLK   : clock, everything on the rising edge
//   ARESET : synchronous active-high reset
//   s_axi  : AXI-Lite slave modport (AW/W/B/AR/R)
//   regs_o : register bank, register i at bits [i*32 +: 32]
//
// Build option
//   AXIL_WSTRB_EN : when defined, WSTRB selects which bytes a write updates;
//                   otherwise every write updates the full word.
//
// Decode: idx = addr[2 +: log2(NUM_REGS)], in range iff addr < NUM_REGS*4,
// addr[1:0] ignored. Out-of-range accesses answer SLVERR and touch nothing.
// ---------------------------------------------------------------------------
module axi_lite_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    axi_lite_slave_regs_if.slave           s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
    localparam int                    IDX_W     = $clog2(NUM_REGS);
    localparam int                    STRB_W    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] RANGE_END = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    // Write path: IDLE collects AW and W (any order), RESP holds BVALID.
    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    // Read path: IDLE waits for AR, RESP holds RVALID.
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    wr_state_t             r_wr_state_reg;
    wr_state_t             w_wr_state_next;
    logic                  r_aw_full_reg;
    logic                  w_aw_full_next;
    logic                  r_w_full_reg;
    logic                  w_w_full_next;
    logic                  r_awready_reg;
    logic                  w_awready_next;
    logic                  r_wready_reg;
    logic                  w_wready_next;
    logic [1:0]            r_bresp_reg;
    logic [ADDR_WIDTH-1:0] r_awaddr_reg;
    logic [DATA_WIDTH-1:0] r_wdata_reg;
    logic [STRB_W-1:0]     w_byte_en;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_commit;
    logic                  w_wr_in_range;
    logic [IDX_W-1:0]      w_wr_idx;

    // ------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------
    rd_state_t             r_rd_state_reg;
    rd_state_t             w_rd_state_next;
    logic                  r_arready_reg;
    logic                  w_arready_next;
    logic [DATA_WIDTH-1:0] r_rdata_reg;
    logic [1:0]            r_rresp_reg;
    logic                  w_ar_hs;
    logic                  w_rd_in_range;
    logic [IDX_W-1:0]      w_rd_idx;

    logic [DATA_WIDTH-1:0] w_bank [NUM_REGS];

    // Readies are registered, so handshakes depend on valids only here.
    assign w_aw_hs = s_axi.AWVALID & r_awready_reg;
    assign w_w_hs  = s_axi.WVALID  & r_wready_reg;
    assign w_ar_hs = s_axi.ARVALID & r_arready_reg;

    assign w_wr_in_range = (r_awaddr_reg < RANGE_END);
    assign w_wr_idx      = r_awaddr_reg[2 +: IDX_W];
    assign w_rd_in_range = (s_axi.ARADDR < RANGE_END);
    assign w_rd_idx      = s_axi.ARADDR[2 +: IDX_W];

`ifdef AXIL_WSTRB_EN
    logic [STRB_W-1:0] r_wstrb_reg;
    assign w_byte_en = r_wstrb_reg;
`else
    assign w_byte_en = '1;
`endif

    // ------------------------------------------------------------------
    // Write FSM: next state and readies
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_state_next = r_wr_state_reg;
        w_aw_full_next  = r_aw_full_reg | w_aw_hs;
        w_w_full_next   = r_w_full_reg  | w_w_hs;
        w_commit        = 1'b0;
        case (r_wr_state_reg)
            WR_IDLE: begin
                // Commit only from latched copies: a same-edge AW+W pair
                // therefore lands one edge later.
                if (r_aw_full_reg && r_w_full_reg) begin
                    w_commit        = 1'b1;
                    w_wr_state_next = WR_RESP;
                    w_aw_full_next  = 1'b0;
                    w_w_full_next   = 1'b0;
                end
            end
            WR_RESP: begin
                if (s_axi.BREADY) begin
                    w_wr_state_next = WR_IDLE;
                end
            end
            default: w_wr_state_next = WR_IDLE;
        endcase
        // A channel is ready only while its slot is empty and no response
        // is pending; this also raises both readies on the first edge
        // after reset.
        w_awready_next = (w_wr_state_next == WR_IDLE) && !w_aw_full_next;
        w_wready_next  = (w_wr_state_next == WR_IDLE) && !w_w_full_next;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_state_reg <= WR_IDLE;
            r_aw_full_reg  <= 1'b0;
            r_w_full_reg   <= 1'b0;
            r_awready_reg  <= 1'b0;
            r_wready_reg   <= 1'b0;
            r_bresp_reg    <= RESP_OKAY;
            r_awaddr_reg   <= '0;
            r_wdata_reg    <= '0;
        end else begin
            r_wr_state_reg <= w_wr_state_next;
            r_aw_full_reg  <= w_aw_full_next;
            r_w_full_reg   <= w_w_full_next;
            r_awready_reg  <= w_awready_next;
            r_wready_reg   <= w_wready_next;
            if (w_aw_hs) begin
                r_awaddr_reg <= s_axi.AWADDR;
            end
            if (w_w_hs) begin
                r_wdata_reg <= s_axi.WDATA;
            end
            if (w_commit) begin
                r_bresp_reg <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

`ifdef AXIL_WSTRB_EN
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstrb_reg <= '0;
        end else if (w_w_hs) begin
            r_wstrb_reg <= s_axi.WSTRB;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Register bank: one word per generate slot, byte-lane enables
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] r_word_reg;
            logic                  w_sel;

            assign w_sel = w_commit && w_wr_in_range && (w_wr_idx == IDX_W'(gi));

            always_ff @(posedge ACLK) begin
                if (ARESET) begin
                    r_word_reg <= '0;
                end else if (w_sel) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_byte_en[b]) begin
                            r_word_reg[8*b +: 8] <= r_wdata_reg[8*b +: 8];
                        end
                    end
                end
            end

            assign w_bank[gi]                              = r_word_reg;
            assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_word_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_state_next = r_rd_state_reg;
        case (r_rd_state_reg)
            RD_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                if (s_axi.RREADY) begin
                    w_rd_state_next = RD_IDLE;
                end
            end
            default: w_rd_state_next = RD_IDLE;
        endcase
        w_arready_next = (w_rd_state_next == RD_IDLE);
    end

    // Data is captured on the AR handshake edge itself; a write committing
    // on that same edge is not yet visible, so the old value is returned.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rd_state_reg <= RD_IDLE;
            r_arready_reg  <= 1'b0;
            r_rdata_reg    <= '0;
            r_rresp_reg    <= RESP_OKAY;
        end else begin
            r_rd_state_reg <= w_rd_state_next;
            r_arready_reg  <= w_arready_next;
            if (w_ar_hs) begin
                r_rdata_reg <= w_rd_in_range ? w_bank[w_rd_idx] : '0;
                r_rresp_reg <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axi.AWREADY = r_awready_reg;
    assign s_axi.WREADY  = r_wready_reg;
    assign s_axi.BVALID  = (r_wr_state_reg == WR_RESP);
    assign s_axi.BRESP   = r_bresp_reg;
    assign s_axi.ARREADY = r_arready_reg;
    assign s_axi.RVALID  = (r_rd_state_reg == RD_RESP);
    assign s_axi.RDATA   = r_rdata_reg;
    assign s_axi.RRESP   = r_rresp_reg;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_slave_regs
//
// Bench for axi_lite_slave_regs: directed scenarios followed by randomized
// single transactions, checked against an array model of the register bank.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_axi_lite_slave_regs;
    localparam int NREGS = 8;

    logic               ACLK;
    logic               ARESET;
    logic [NREGS*32-1:0] regs_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_regs [NREGS];

    axi_lite_slave_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axi_lite_slave_regs #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (NREGS)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .s_axi  (axi),
        .regs_o (regs_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] model_write(input logic [31:0] addr,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        int idx;
        if (addr >= 32'(NREGS * 4)) return 2'b10;
        idx = int'(addr) / 4;
        for (int b = 0; b < 4; b++)
            if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] addr);
        if (addr >= 32'(NREGS * 4)) return 32'h0;
        return model_regs[int'(addr) / 4];
    endfunction

    function automatic logic [1:0] model_rresp(input logic [31:0] addr);
        return (addr >= 32'(NREGS * 4)) ? 2'b10 : 2'b00;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) model_regs[i] = 32'h0;
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < NREGS; i++)
            check_val($sformatf("%s_reg%0d", tag, i), regs_o[i*32 +: 32], model_regs[i]);
    endtask

    task automatic tick();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    // ---------------- write transaction (entered on a falling edge) -------
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_delay,
                            input int w_delay, input int b_delay);
        bit          aw_done = 0;
        bit          w_done  = 0;
        bit          aw_go;
        bit          w_go;
        int          t = 0;
        logic [1:0]  exp_resp;
        logic [3:0]  eff_strb;
`ifdef AXIL_WSTRB_EN
        eff_strb = strb;
`else
        eff_strb = 4'hF;
`endif
        while (!(aw_done && w_done)) begin
            if (t > 60) begin
                axi.AWVALID = 0;
                axi.WVALID  = 0;
                check_val("wr_hs_timeout", {aw_done, w_done}, 2'b11);
                return;
            end
            if (!aw_done && t >= aw_delay) begin
                axi.AWVALID = 1;
                axi.AWADDR  = addr;
            end
            if (!w_done && t >= w_delay) begin
                axi.WVALID = 1;
                axi.WDATA  = data;
`ifdef AXIL_WSTRB_EN
                axi.WSTRB  = strb;
`endif
            end
            aw_go = axi.AWVALID && axi.AWREADY;
            w_go  = axi.WVALID && axi.WREADY;
            tick();
            t++;
            if (aw_go) begin aw_done = 1; axi.AWVALID = 0; end
            if (w_go)  begin w_done  = 1; axi.WVALID  = 0; end
            if (w_done && !aw_done) begin
                check_val("wready_after_w", axi.WREADY, 1'b0);
                check_val("no_commit_wo_aw", axi.BVALID, 1'b0);
            end
            if (aw_done && !w_done) begin
                check_val("awready_after_aw", axi.AWREADY, 1'b0);
                check_val("no_commit_wo_w", axi.BVALID, 1'b0);
            end
        end
        check_val("b_not_early", axi.BVALID, 1'b0);
        tick();
        exp_resp = model_write(addr, data, eff_strb);
        check_val("b_latency", axi.BVALID, 1'b1);
        check_val("bresp", axi.BRESP, exp_resp);
        check_bank("wr");
        for (int i = 0; i < b_delay; i++) begin
            tick();
            check_val("bvalid_hold", axi.BVALID, 1'b1);
            check_val("bresp_hold", axi.BRESP, exp_resp);
            check_val("awready_stall", axi.AWREADY, 1'b0);
            check_val("wready_stall", axi.WREADY, 1'b0);
        end
        axi.BREADY = 1;
        tick();
        axi.BREADY = 0;
        check_val("bvalid_drop", axi.BVALID, 1'b0);
        check_val("awready_back", axi.AWREADY, 1'b1);
        check_val("wready_back", axi.WREADY, 1'b1);
        $display("[TB] WR addr=%08h data=%08h strb=%h resp=%0d", addr, data, eff_strb, exp_resp);
    endtask

    // ---------------- read transaction (entered on a falling edge) --------
    task automatic do_read(input logic [31:0] addr, input int ar_delay,
                           input int r_delay, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
        bit done = 0;
        bit go;
        int t = 0;
        while (!done) begin
            if (t > 60) begin
                axi.ARVALID = 0;
                check_val("rd_hs_timeout", done, 1'b1);
                return;
            end
            if (t >= ar_delay) begin
                axi.ARVALID = 1;
                axi.ARADDR  = addr;
            end
            go = axi.ARVALID && axi.ARREADY;
            tick();
            t++;
            if (go) begin done = 1; axi.ARVALID = 0; end
        end
        check_val("r_latency", axi.RVALID, 1'b1);
        check_val("arready_busy", axi.ARREADY, 1'b0);
        check_val("rdata", axi.RDATA, exp_data);
        check_val("rresp", axi.RRESP, exp_resp);
        for (int i = 0; i < r_delay; i++) begin
            tick();
            check_val("rvalid_hold", axi.RVALID, 1'b1);
            check_val("rdata_hold", axi.RDATA, exp_data);
            check_val("rresp_hold", axi.RRESP, exp_resp);
            check_val("arready_stall", axi.ARREADY, 1'b0);
        end
        axi.RREADY = 1;
        tick();
        axi.RREADY = 0;
        check_val("rvalid_drop", axi.RVALID, 1'b0);
        check_val("arready_back", axi.ARREADY, 1'b1);
        $display("[TB] RD addr=%08h data=%08h resp=%0d", addr, exp_data, exp_resp);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_awready"}, axi.AWREADY, 1'b0);
        check_val({tag, "_wready"},  axi.WREADY,  1'b0);
        check_val({tag, "_arready"}, axi.ARREADY, 1'b0);
        check_val({tag, "_bvalid"},  axi.BVALID,  1'b0);
        check_val({tag, "_bresp"},   axi.BRESP,   2'b00);
        check_val({tag, "_rvalid"},  axi.RVALID,  1'b0);
        check_val({tag, "_rdata"},   axi.RDATA,   32'h0);
        check_val({tag, "_rresp"},   axi.RRESP,   2'b00);
        check_bank(tag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;

        ARESET      = 1;
        axi.AWADDR  = '0;
        axi.AWVALID = 0;
        axi.WDATA   = '0;
`ifdef AXIL_WSTRB_EN
        axi.WSTRB   = '0;
`endif
        axi.WVALID  = 0;
        axi.BREADY  = 0;
        axi.ARADDR  = '0;
        axi.ARVALID = 0;
        axi.RREADY  = 0;
        model_clear();

        // Reset state and ready rise one edge after release.
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check_all_zero("rst");
        ARESET = 0;
        tick();
        check_val("rel_awready", axi.AWREADY, 1'b1);
        check_val("rel_wready",  axi.WREADY,  1'b1);
        check_val("rel_arready", axi.ARREADY, 1'b1);

        // Same-cycle AW/W, immediate B, read back.
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(32'h04, 0, 0, model_rdata(32'h04), model_rresp(32'h04));

        // W leads AW by three cycles.
        do_write(32'h08, 32'h12345678, 4'hF, 3, 0, 0);
        // AW leads W.
        do_write(32'h18, 32'hCAFEF00D, 4'hF, 0, 2, 0);

        // Out of range both ways.
        do_write(32'h20, 32'h55555555, 4'hF, 0, 0, 0);
        do_read(32'h20, 0, 0, model_rdata(32'h20), model_rresp(32'h20));

        // Back-pressure on B and R.
        do_write(32'h10, 32'h0BADC0DE, 4'hF, 0, 0, 5);
        do_read(32'h10, 0, 5, model_rdata(32'h10), model_rresp(32'h10));

        // Read captured on the commit edge of a write to the same register.
        do_write(32'h0C, 32'h11111111, 4'hF, 0, 0, 0);
        fork
            do_write(32'h0C, 32'hAAAA5555, 4'hF, 0, 0, 0);
            do_read(32'h0C, 1, 0, 32'h11111111, 2'b00);
        join
        do_read(32'h0C, 0, 0, model_rdata(32'h0C), model_rresp(32'h0C));

        // Randomized single transactions (includes unaligned and
        // out-of-range byte addresses).
        for (int it = 0; it < 60; it++) begin
            a = 32'($urandom_range(0, NREGS * 4 + 7));
            d = $urandom;
`ifdef AXIL_WSTRB_EN
            s = 4'($urandom_range(0, 15));
`else
            s = 4'hF;
`endif
            if ($urandom_range(0, 1) == 1)
                do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3), $urandom_range(0, 3),
                        model_rdata(a), model_rresp(a));
        end

        // Reset with both a B and an R response pending.
        axi.AWVALID = 1; axi.AWADDR = 32'h14; axi.WVALID = 1; axi.WDATA = 32'h76543210;
`ifdef AXIL_WSTRB_EN
        axi.WSTRB = 4'hF;
`endif
        axi.ARVALID = 1; axi.ARADDR = 32'h04;
        tick();
        axi.AWVALID = 0; axi.WVALID = 0; axi.ARVALID = 0;
        tick();
        check_val("pre_rst_bvalid", axi.BVALID, 1'b1);
        check_val("pre_rst_rvalid", axi.RVALID, 1'b1);
        ARESET = 1;
        tick();
        model_clear();
        check_all_zero("midrst");
        ARESET = 0;
        axi.BREADY = 1;
        axi.RREADY = 1;
        tick();
        check_val("rerel_awready", axi.AWREADY, 1'b1);
        check_val("rerel_wready",  axi.WREADY,  1'b1);
        check_val("rerel_arready", axi.ARREADY, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_val("no_stale_b", axi.BVALID, 1'b0);
            check_val("no_stale_r", axi.RVALID, 1'b0);
            tick();
        end
        axi.BREADY = 0;
        axi.RREADY = 0;

`ifdef AXIL_WSTRB_EN
        // Partial strobe over a cleared register, then an empty strobe.
        do_write(32'h00, 32'hFFFFFFFF, 4'b0011, 0, 0, 0);
        check_val("strb_lo_half", regs_o[31:0], 32'h0000FFFF);
        do_write(32'h00, 32'h12345678, 4'b0000, 0, 0, 0);
        do_read(32'h00, 0, 0, model_rdata(32'h00), model_rresp(32'h00));
`else
        do_write(32'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        do_read(32'h00, 0, 0, model_rdata(32'h00), model_rresp(32'h00));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
AXI-Lite responder (slave) that terminates the AXI-Lite master channels and exposes a bank of NUM_REGS read/write registers. The bank is mirrored onto a flat output bus for downstream fabric. It is the DUT-side counterpart to the bench's AXI-Lite master driver. It supports one outstanding write and one outstanding read, with independent write and read paths.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width; must be 32 (word = 4 bytes)
NUM_REGS, 8, number of 32-bit registers; power of two, >= 2

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous active-high reset
AWADDR  in  ADDR_WIDTH  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  master ready for response
ARADDR  in  ADDR_WIDTH  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  master ready for read data
regs_o  out  NUM_REGS*DATA_WIDTH  register bank; reg i at bits [i*32 +: 32]

Behaviour:
- Reset (ARESET=1 at an edge):
  - All outputs go to 0, including AWREADY, WREADY, ARREADY and the register bank.
  - In-flight transactions are discarded; no response is issued for them.
  - The first edge with ARESET=0 sets AWREADY, WREADY and ARREADY to 1.
- Decode:
  - idx = addr[2 +: log2(NUM_REGS)].
  - In range iff addr < NUM_REGS*4.
  - addr[1:0] is ignored.
  - Responses: OKAY=2'b00; out of range gives SLVERR=2'b10.
- Write path (registered, one outstanding):
  - AW handshake (AWVALID&AWREADY): latch AWADDR; AWREADY<=0.
  - W handshake (WVALID&WREADY): latch WDATA; WREADY<=0.
  - AW and W may arrive in either order or on the same edge.
  - Commit edge: the first edge where both are latched and BVALID=0.
    - In range: reg[idx]<=data and BRESP<=OKAY.
    - Out of range: no register changes and BRESP<=SLVERR.
    - BVALID<=1 on the same edge.
  - Latency: if both handshakes occur at edge N, the register and BVALID update at edge N+1.
  - BVALID and BRESP are held stable until BREADY. On the B handshake: BVALID<=0, AWREADY<=1, WREADY<=1.
- Read path (registered, one outstanding):
  - AR handshake at edge N: ARREADY<=0; RDATA<=in-range ? reg[idx] : 0; RRESP<=OKAY/SLVERR; RVALID<=1, all at edge N.
  - RDATA, RRESP and RVALID are held stable until RREADY. On the R handshake: RVALID<=0, ARREADY<=1.
- Simultaneous events:
  - A read capture on the same edge as a write commit to the same register returns the old value.
  - The read and write paths never stall each other.
- Valid/ready rules: readies never depend combinationally on valids. Asserting valid while ready=0 has no effect until ready=1.
- regs_o reflects the bank directly; it updates on the commit edge.

Optional Feature:
AXIL_WSTRB_EN:
- Defined:
  - Adds port WSTRB (in, DATA_WIDTH/8), latched with WDATA on the W handshake.
  - At commit, only bytes with WSTRB[b]=1 update reg[idx][8b +: 8].
  - WSTRB=0 on an in-range address returns OKAY with no change.
- Undefined: no WSTRB port; every write updates all 4 bytes.

Test Plan:
- Reset then AW 0x04/W 0xDEADBEEF on the same cycle, BREADY=1 -> BVALID one cycle later with BRESP=00; regs_o[63:32]=0xDEADBEEF; read 0x04 gives RDATA=0xDEADBEEF, RRESP=00, RVALID one cycle after the AR handshake.
- W 0x12345678 three cycles before AW 0x08 -> WREADY=0 after W, no commit until AW; then BVALID one cycle after AW; reg2=0x12345678.
- Write 0x20 (NUM_REGS=8), then read 0x20 -> BRESP=10, bank unchanged; RRESP=10, RDATA=0.
- BREADY held 0 for 5 cycles -> BVALID/BRESP stable; AWREADY=WREADY=0; a second AW is not accepted until the B handshake; same check for RVALID with RREADY=0.
- Write 0xAAAA5555 to 0x0C committing on the same edge as a read of 0x0C (prior 0x11111111) -> RDATA=0x11111111; a subsequent read returns 0xAAAA5555.
- ARESET asserted while BVALID=1 and RVALID=1 -> next edge all outputs 0 and regs_o=0; one edge after deassertion the readies are 1; no stale B/R is issued (with AXIL_WSTRB_EN: WSTRB=4'b0011, data 0xFFFFFFFF over 0 gives 0x0000FFFF).
